// File: rtl/data_memory.sv
// Data-memory responder: fixed-latency request/stall handshake with RV32 byte-lane
// stores and sign/zero-extended loads. Optional alignment checking: DATA_MEM_ALIGN_CHECK_EN.
module data_memory #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [3:0]  READ,
  input  logic [2:0]  WRITE,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] WRITEDATA,
  output logic [31:0] READDATA,
  output logic        BUSYWAIT,
  output logic        ERROR
);

  localparam int WORDS = 2 ** (ADDR_WIDTH - 2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [2:0]              rd_q, rd_d;
  logic [2:0]              wr_q, wr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic [31:0]             mem_q [WORDS];

  logic                    req_s;
  logic                    busy_s;
  logic                    mem_we_s;
  logic [1:0]              lane_s;
  logic [ADDR_WIDTH-3:0]   widx_s;
  logic [31:0]             word_s;
  logic [31:0]             wword_s;
  logic                    wr_ok_s;
  logic [7:0]              byte_s;
  logic [15:0]             half_s;
  logic [31:0]             rd_val_s;
  logic                    acc_err_s;
  logic                    unused_addr_s;

  assign req_s         = READ[3] | WRITE[2];
  assign unused_addr_s = ^ADDRESS[31:ADDR_WIDTH];
  assign lane_s        = addr_q[1:0];
  assign widx_s        = addr_q[ADDR_WIDTH-1:2];
  assign word_s        = mem_q[widx_s];
  assign byte_s        = word_s[{lane_s, 3'b000} +: 8];
  assign half_s        = word_s[{lane_s[1], 4'b0000} +: 16];

  // Lane decode of the latched request; using only the upper lane bit for
  // halfwords and none for words aligns misaligned accesses down.
  always_comb begin
    wword_s  = word_s;
    wr_ok_s  = 1'b0;
    rd_val_s = 32'd0;
    case (wr_q[1:0])
      2'b00: begin
        wr_ok_s = 1'b1;
        wword_s[{lane_s, 3'b000} +: 8] = wdata_q[7:0];
      end
      2'b01: begin
        wr_ok_s = 1'b1;
        wword_s[{lane_s[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
      2'b10: begin
        wr_ok_s = 1'b1;
        wword_s = wdata_q;
      end
      default: wr_ok_s = 1'b0;
    endcase
    case (rd_q)
      3'b000:  rd_val_s = {{24{byte_s[7]}}, byte_s};
      3'b001:  rd_val_s = {{16{half_s[15]}}, half_s};
      3'b010:  rd_val_s = word_s;
      3'b100:  rd_val_s = {24'd0, byte_s};
      3'b101:  rd_val_s = {16'd0, half_s};
      default: rd_val_s = 32'd0;
    endcase
`ifdef DATA_MEM_ALIGN_CHECK_EN
    if (wr_q[2]) begin
      acc_err_s = (wr_q[1:0] == 2'b11)
                | ((wr_q[1:0] == 2'b01) & lane_s[0])
                | ((wr_q[1:0] == 2'b10) & (lane_s != 2'b00));
    end else begin
      acc_err_s = (rd_q == 3'b011) | (rd_q == 3'b110) | (rd_q == 3'b111)
                | (((rd_q == 3'b001) | (rd_q == 3'b101)) & lane_s[0])
                | ((rd_q == 3'b010) & (lane_s != 2'b00));
    end
    if (acc_err_s) begin
      wr_ok_s  = 1'b0;
      rd_val_s = 32'd0;
    end else begin
      wr_ok_s  = wr_ok_s;
    end
`else
    acc_err_s = 1'b0;
`endif
  end

  // Next-state, handshake and access-completion logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = 1'b0;
    mem_we_s = 1'b0;
    busy_s   = 1'b0;
    case (state_q)
      IDLE: begin
        busy_s = req_s;
        if (req_s) begin
          rd_d    = READ[2:0];
          wr_d    = WRITE;
          addr_d  = ADDRESS[ADDR_WIDTH-1:0];
          wdata_d = WRITEDATA;
          cnt_d   = 8'(LATENCY - 1);
          state_d = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        busy_s = 1'b1;
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d  = DONE;
          err_d    = acc_err_s;
          mem_we_s = wr_q[2] & wr_ok_s;
          if (!wr_q[2]) begin
            rdata_d = rd_val_s;
          end else begin
            rdata_d = rdata_q;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (RESET) begin
      busy_s   = 1'b0;
      mem_we_s = 1'b0;
    end else begin
      busy_s   = busy_s;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      rd_q    <= 3'd0;
      wr_q    <= 3'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage array; contents survive reset.
  always_ff @(posedge CLK) begin
    if (mem_we_s) begin
      mem_q[widx_s] <= wword_s;
    end
  end

  assign BUSYWAIT = busy_s;
  assign READDATA = rdata_q;
  assign ERROR    = err_q;

endmodule
